reg_writeback_unit: RTL
=======================

# reg_writeback_unit

Writer side of the integer register file in the RISC-V core. Accepts destination-register results from the ALU and load paths over valid/ready handshakes and buffers them in a small in-order queue. Drains the queue into the register file's single write port one entry per cycle, yielding whenever the decode stage needs that port for a read. Exposes two forwarding lookups so decode can see results not yet committed to the register file.

## Interface
- XLEN, 32, data width
- REG_W, 5, register index width
- DEPTH, 4, queue entries (power of two, ≥2)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_ld_valid  in  1  load result valid
- o_ld_ready  out  1  load result accepted
- i_ld_rd  in  REG_W  load destination
- i_ld_val  in  XLEN  load data
- i_alu_valid  in  1  ALU result valid
- o_alu_ready  out  1  ALU result accepted
- i_alu_rd  in  REG_W  ALU destination
- i_alu_val  in  XLEN  ALU data
- i_rd_req  in  1  decode owns the register-file port this cycle; no write may issue
- o_w_en  out  1  write strobe to register file (drives its op select: 1 = write)
- o_w_reg_num  out  REG_W  write index
- o_w_val  out  XLEN  write data
- i_fwd_reg_1, i_fwd_reg_2  in  REG_W  forwarding query indices
- o_fwd_hit_1, o_fwd_hit_2  out  1  query matches a pending entry
- o_fwd_val_1, o_fwd_val_2  out  XLEN  youngest matching value
- o_count  out  $clog2(DEPTH)+1  entries queued (excludes output register)

## Operation
- Acceptance: at most one result per cycle; load has priority (older instruction).
  - o_ld_ready = (o_count < DEPTH).
  - o_alu_ready = (o_count < DEPTH) && !i_ld_valid.
  - Both are registered-state functions only; a pop in the same cycle does not free space early.
- rd = 0: handshake completes, nothing enqueued or written, o_count unchanged.
- Drain, evaluated at each edge when not in reset:
  - i_rd_req=1: o_w_en←0; no pop; accepted input enqueued.
  - i_rd_req=0, queue non-empty: o_w_en←1, o_w_*←head, pop. An accepted input is enqueued in the same edge, so o_count is unchanged.
  - i_rd_req=0, queue empty, input accepted (rd≠0): bypass; o_w_en←1, o_w_*←input; not enqueued.
  - Otherwise o_w_en←0; o_w_reg_num and o_w_val hold.
- Order: register-file writes occur in acceptance order.
- Forwarding (combinational):
  - Pending set = queued entries, plus the output register while o_w_en=1.
  - Search order, youngest first: tail−1 down to head, then the output register.
  - A query for index 0 always misses. A miss returns value 0.
- Pointers are REG-width-free circular indices mod DEPTH; o_count ranges 0..DEPTH.

## Timing
- Reset values: o_w_en=0, o_w_reg_num=0, o_w_val=0, o_count=0, pointers 0, o_ld_ready=o_alu_ready=1, o_fwd_hit_*=0.
- Latency with an empty queue and i_rd_req=0: accepted at edge N → o_w_en=1 during cycle N+1.
- Throughput: one write per cycle while i_rd_req=0.
- o_w_en is a one-cycle pulse per entry.
- Reset mid-operation: all queued entries and any pending write are discarded; o_w_en=0 in the cycle after the reset edge.
- The handshake completes on the edge where valid&&ready=1. Producers hold rd/val stable until then.

## Structure
- Shared package wb_pkg:
  - XLEN and REG_W constants.
  - typedef wb_entry_t {rd, val}.
- Sub-module wb_fifo: circular buffer of wb_entry_t with push/pop, count, and two combinational youngest-first search ports.
- The top level holds arbitration, bypass, the output register and output-register forwarding.

## Test plan
- Reset: assert i_rst 2 cycles → o_w_en=0, o_count=0, both ready=1, fwd hits 0.
- Bypass: ALU rd=5 val=0xDEADBEEF at edge N, i_rd_req=0 → cycle N+1 o_w_en=1, reg 5, val 0xDEADBEEF; cycle N+2 o_w_en=0.
- Priority: ld rd=3 val=0x11 and ALU rd=4 val=0x22 in the same cycle → o_ld_ready=1, o_alu_ready=0. Writes reg 3 then reg 4 on consecutive cycles.
- Stall/full/forward: hold i_rd_req=1 and push rd 1,2,3,2 with vals 0x10,0x20,0x30,0x40 → o_count=4, both ready=0. Query rd 2 → hit, 0x40; query rd 0 → miss. Release i_rd_req → four consecutive writes (1,0x10)(2,0x20)(3,0x30)(2,0x40).
- x0 drop: ALU rd=0 val=0xFF → handshake completes, no o_w_en, o_count unchanged, fwd query 0 misses.
- Reset mid-drain: o_count=3 with i_rd_req=1, assert i_rst → next cycle o_count=0, o_w_en=0. No writes after deassert and i_rd_req=0.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Brief    : Shared widths and queue entry type for the register writeback path
//  Revision : 1.0
// ============================================================================
package wb_pkg;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  val;
    } wb_entry_t;
endpackage
`default_nettype wire

// File: rtl/reg_writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_writeback_unit_if
//  Brief    : Producer handshakes, register-file write port and forwarding bus
//  Revision : 1.0
// ============================================================================
interface reg_writeback_unit_if #(
    parameter int DEPTH = 4
);
    import wb_pkg::*;

    logic                       i_ld_valid;
    logic                       o_ld_ready;
    logic [REG_W-1:0]           i_ld_rd;
    logic [XLEN-1:0]            i_ld_val;
    logic                       i_alu_valid;
    logic                       o_alu_ready;
    logic [REG_W-1:0]           i_alu_rd;
    logic [XLEN-1:0]            i_alu_val;
    logic                       i_rd_req;
    logic                       o_w_en;
    logic [REG_W-1:0]           o_w_reg_num;
    logic [XLEN-1:0]            o_w_val;
    logic [REG_W-1:0]           i_fwd_reg_1;
    logic [REG_W-1:0]           i_fwd_reg_2;
    logic                       o_fwd_hit_1;
    logic                       o_fwd_hit_2;
    logic [XLEN-1:0]            o_fwd_val_1;
    logic [XLEN-1:0]            o_fwd_val_2;
    logic [$clog2(DEPTH):0]     o_count;

    modport slave (
        input  i_ld_valid, i_ld_rd, i_ld_val,
        input  i_alu_valid, i_alu_rd, i_alu_val,
        input  i_rd_req, i_fwd_reg_1, i_fwd_reg_2,
        output o_ld_ready, o_alu_ready,
        output o_w_en, o_w_reg_num, o_w_val,
        output o_fwd_hit_1, o_fwd_hit_2, o_fwd_val_1, o_fwd_val_2,
        output o_count
    );

    modport master (
        output i_ld_valid, i_ld_rd, i_ld_val,
        output i_alu_valid, i_alu_rd, i_alu_val,
        output i_rd_req, i_fwd_reg_1, i_fwd_reg_2,
        input  o_ld_ready, o_alu_ready,
        input  o_w_en, o_w_reg_num, o_w_val,
        input  o_fwd_hit_1, o_fwd_hit_2, o_fwd_val_1, o_fwd_val_2,
        input  o_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Brief    : Circular buffer of writeback entries with two youngest-first lookups
//  Revision : 1.0
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic             i_push,
    input  wire wb_entry_t        i_din,
    input  wire logic             i_pop,
    output wb_entry_t             o_head,
    output logic [CNT_W-1:0]      o_count,
    input  wire logic [REG_W-1:0] i_q_rd_1,
    input  wire logic [REG_W-1:0] i_q_rd_2,
    output logic                  o_hit_1,
    output logic                  o_hit_2,
    output logic [XLEN-1:0]       o_val_1,
    output logic [XLEN-1:0]       o_val_2
);
    wb_entry_t         r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_idx;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PTR_W'(1);
            if (i_pop)  r_head <= r_head + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

    // Walk from tail-1 back towards head; the first match is the youngest.
    always_comb begin
        o_hit_1 = 1'b0;
        o_hit_2 = 1'b0;
        o_val_1 = '0;
        o_val_2 = '0;
        w_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_tail - PTR_W'(i + 1);
            if (CNT_W'(i) < r_count) begin
                if (!o_hit_1 && i_q_rd_1 != '0 && r_mem[w_idx].rd == i_q_rd_1) begin
                    o_hit_1 = 1'b1;
                    o_val_1 = r_mem[w_idx].val;
                end
                if (!o_hit_2 && i_q_rd_2 != '0 && r_mem[w_idx].rd == i_q_rd_2) begin
                    o_hit_2 = 1'b1;
                    o_val_2 = r_mem[w_idx].val;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : reg_writeback_unit
//  Brief    : Arbitrates ALU/load results, queues them and drains to the regfile
//  Revision : 1.0
// ============================================================================
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst,
    reg_writeback_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             r_w_en;
    logic [REG_W-1:0] r_w_reg_num;
    logic [XLEN-1:0]  r_w_val;

    wb_entry_t        w_head;
    wb_entry_t        w_in;
    logic [CNT_W-1:0] w_count;
    logic             w_full, w_empty;
    logic             w_ld_acc, w_alu_acc, w_in_live;
    logic             w_pop, w_push, w_bypass;
    logic             w_q_hit_1, w_q_hit_2;
    logic [XLEN-1:0]  w_q_val_1, w_q_val_2;

    assign w_full  = (w_count == CNT_W'(DEPTH));
    assign w_empty = (w_count == '0);

    assign bus.o_ld_ready  = !w_full;
    assign bus.o_alu_ready = !w_full && !bus.i_ld_valid;

    assign w_ld_acc  = bus.i_ld_valid  && bus.o_ld_ready;
    assign w_alu_acc = bus.i_alu_valid && bus.o_alu_ready;
    assign w_in      = w_ld_acc ? '{rd: bus.i_ld_rd,  val: bus.i_ld_val}
                                : '{rd: bus.i_alu_rd, val: bus.i_alu_val};
    // Writes to x0 complete the handshake but are discarded here.
    assign w_in_live = (w_ld_acc || w_alu_acc) && (w_in.rd != '0);

    assign w_pop    = !bus.i_rd_req && !w_empty;
    assign w_bypass = !bus.i_rd_req &&  w_empty && w_in_live;
    assign w_push   = w_in_live && !w_bypass;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_push   (w_push),
        .i_din    (w_in),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count),
        .i_q_rd_1 (bus.i_fwd_reg_1),
        .i_q_rd_2 (bus.i_fwd_reg_2),
        .o_hit_1  (w_q_hit_1),
        .o_hit_2  (w_q_hit_2),
        .o_val_1  (w_q_val_1),
        .o_val_2  (w_q_val_2)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_w_en      <= 1'b0;
            r_w_reg_num <= '0;
            r_w_val     <= '0;
        end else if (w_pop) begin
            r_w_en      <= 1'b1;
            r_w_reg_num <= w_head.rd;
            r_w_val     <= w_head.val;
        end else if (w_bypass) begin
            r_w_en      <= 1'b1;
            r_w_reg_num <= w_in.rd;
            r_w_val     <= w_in.val;
        end else begin
            r_w_en      <= 1'b0;
        end
    end

    assign bus.o_w_en      = r_w_en;
    assign bus.o_w_reg_num = r_w_reg_num;
    assign bus.o_w_val     = r_w_val;
    assign bus.o_count     = w_count;

    // The output register is older than anything queued, so it only answers on a queue miss.
    always_comb begin
        bus.o_fwd_hit_1 = w_q_hit_1;
        bus.o_fwd_val_1 = w_q_val_1;
        bus.o_fwd_hit_2 = w_q_hit_2;
        bus.o_fwd_val_2 = w_q_val_2;
        if (!w_q_hit_1 && r_w_en && bus.i_fwd_reg_1 != '0 && r_w_reg_num == bus.i_fwd_reg_1) begin
            bus.o_fwd_hit_1 = 1'b1;
            bus.o_fwd_val_1 = r_w_val;
        end
        if (!w_q_hit_2 && r_w_en && bus.i_fwd_reg_2 != '0 && r_w_reg_num == bus.i_fwd_reg_2) begin
            bus.o_fwd_hit_2 = 1'b1;
            bus.o_fwd_val_2 = r_w_val;
        end
    end
endmodule
`default_nettype wire
